// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: DATA_WIDTH edges after accept for normal ops, result visible the cycle after accept for fast-path cases.
// Backpressure: ready_o low while iterating; start_i is dropped then, kill_i aborts to IDLE at any time.
module ex_muldiv_unit #(
    // Operand width; must be even and at least 4.
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    input  logic                  kill_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_funct3;
    logic            r_neg;      // sign to apply to the selected result at the final step
    logic [W-1:0]    r_hi;       // multiply: product high half; divide: partial remainder
    logic [W-1:0]    r_lo;       // multiply: multiplier/product low half; divide: dividend/quotient
    logic [W-1:0]    r_mcand;    // multiply: multiplicand magnitude; divide: divisor magnitude
    logic [W-1:0]    r_result;

    // Accept-time decode
    logic            w_accept;
    logic            w_is_div;
    logic            w_op1_signed;
    logic            w_op2_signed;
    logic            w_neg1;
    logic            w_neg2;
    logic [W-1:0]    w_mag1;
    logic [W-1:0]    w_mag2;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [W-1:0]    w_fast_result;
    logic            w_neg_sel;

    // Iteration datapath
    logic [W:0]      w_sum;
    logic [W:0]      w_shift;
    logic            w_ge;
    logic [W-1:0]    w_sub;
    logic [W-1:0]    w_step_hi;
    logic [W-1:0]    w_step_lo;
    logic            w_last;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_prod_s;
    logic [W-1:0]    w_quo_s;
    logic [W-1:0]    w_rem_s;
    logic [W-1:0]    w_final;

    // Decode the request: signedness, magnitudes, and the cases answered without iterating
    always_comb begin
        w_accept     = start_i & ready_o & ~kill_i;
        w_is_div     = funct3_i[2];
        // MUL/MULH/MULHSU take op1 as signed; only MUL/MULH take op2 as signed
        w_op1_signed = w_is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
        w_op2_signed = w_is_div ? ~funct3_i[0] : ~funct3_i[1];
        w_neg1       = w_op1_signed & operand1_i[W-1];
        w_neg2       = w_op2_signed & operand2_i[W-1];
        w_mag1       = w_neg1 ? ({W{1'b0}} - operand1_i) : operand1_i;
        w_mag2       = w_neg2 ? ({W{1'b0}} - operand2_i) : operand2_i;
        w_div_zero   = (operand2_i == {W{1'b0}});
        w_ovf        = ~funct3_i[0] & (operand1_i == MIN_NEG) & (operand2_i == {W{1'b1}});
        w_special    = w_is_div & (w_div_zero | w_ovf);
        if (w_div_zero) begin
            w_fast_result = funct3_i[1] ? operand1_i : {W{1'b1}};
        end else begin
            w_fast_result = funct3_i[1] ? {W{1'b0}} : MIN_NEG;
        end
        // Remainder follows the dividend's sign; everything else is the XOR of operand signs
        w_neg_sel = (w_is_div & funct3_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
    end

    // One radix-2 step of multiply or divide, plus sign fix-up and result select for the last step
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
        w_shift = {r_hi, r_lo[W-1]};
        w_ge    = (w_shift >= {1'b0, r_mcand});
        // When w_ge holds the difference is below the divisor, so the low W bits are exact
        w_sub   = w_shift[W-1:0] - r_mcand;
        if (r_funct3[2]) begin
            w_step_hi = w_ge ? w_sub : w_shift[W-1:0];
            w_step_lo = {r_lo[W-2:0], w_ge};
        end else begin
            w_step_hi = w_sum[W:1];
            w_step_lo = {w_sum[0], r_lo[W-1:1]};
        end
        w_last   = (r_count == LAST_CNT);
        w_prod   = {w_step_hi, w_step_lo};
        w_prod_s = r_neg ? ({(2*W){1'b0}} - w_prod) : w_prod;
        w_quo_s  = r_neg ? ({W{1'b0}} - w_step_lo) : w_step_lo;
        w_rem_s  = r_neg ? ({W{1'b0}} - w_step_hi) : w_step_hi;
        case (r_funct3)
            3'b000:         w_final = w_prod_s[W-1:0];
            3'b100, 3'b101: w_final = w_quo_s;
            3'b110, 3'b111: w_final = w_rem_s;
            default:        w_final = w_prod_s[2*W-1:W];
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; kill overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (kill_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        ready_o  = (r_state == S_IDLE) || (r_state == S_DONE);
        done_o   = (r_state == S_DONE);
        result_o = r_result;
        zero_o   = (r_result == {W{1'b0}});
    end

    // Operand load at accept, iteration in CALC, result write on the final step or fast path
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_funct3 <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_result <= '0;
        end else if (!kill_i) begin
            if (w_accept) begin
                r_funct3 <= funct3_i;
                r_neg    <= w_neg_sel;
                r_count  <= '0;
                r_hi     <= '0;
                if (w_is_div) begin
                    r_mcand <= w_mag2;
                    r_lo    <= w_mag1;
                end else begin
                    r_mcand <= w_mag1;
                    r_lo    <= w_mag2;
                end
                if (w_special) begin
                    r_result <= w_fast_result;
                end
            end else if (r_state == S_CALC) begin
                r_hi    <= w_step_hi;
                r_lo    <= w_step_lo;
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_result <= w_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table plus kill, reset and back-to-back sequences.
// Latency is counted as rising edges after the accept edge until done_o is seen.
// Includes a DATA_WIDTH=8 instance for the narrow-width multiply case.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        kill = 1'b0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;

    logic        s8_start = 1'b0;
    logic [2:0]  s8_funct3 = 3'b000;
    logic [7:0]  s8_op1 = '0;
    logic [7:0]  s8_op2 = '0;
    logic        s8_kill = 1'b0;
    logic        s8_ready;
    logic        s8_done;
    logic [7:0]  s8_result;
    logic        s8_zero;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
        .operand1_i(op1), .operand2_i(op2), .kill_i(kill),
        .ready_o(ready), .done_o(done), .result_o(result), .zero_o(zero)
    );

    ex_muldiv_unit #(.DATA_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8_start), .funct3_i(s8_funct3),
        .operand1_i(s8_op1), .operand2_i(s8_op2), .kill_i(s8_kill),
        .ready_o(s8_ready), .done_o(s8_done), .result_o(s8_result), .zero_o(s8_zero)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_zero;
        int          lat;
    } vec_t;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from a ready state and wait (bounded) for its done pulse.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output logic z,
                          output int lat, output int done_cyc);
        @(negedge clk);
        check({name, "_ready"}, ready, 1'b1);
        start = 1'b1; funct3 = f; op1 = a; op2 = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        res = result;
        z = zero;
        done_cyc = cyc;
    endtask

    task automatic watch_no_done(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        check(name, seen, 1'b0);
    endtask

    vec_t        tbl [16];
    logic [31:0] r;
    logic        z;
    int          lat;
    int          dc1;
    int          dc2;
    logic [31:0] prior;

    initial begin
        // Normal ops complete 32 edges after accept; fast-path done is visible right after the accept edge.
        tbl[0]  = '{F_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32};
        tbl[1]  = '{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 32};
        tbl[2]  = '{F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32};
        tbl[3]  = '{F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32};
        tbl[4]  = '{F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 32};
        tbl[5]  = '{F_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0, 32};
        tbl[6]  = '{F_DIV,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA, 1'b0, 32};
        tbl[7]  = '{F_REM,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE, 1'b0, 32};
        tbl[8]  = '{F_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32};
        tbl[9]  = '{F_REM,    32'h00000014, 32'hFFFFFFFD, 32'h00000002, 1'b0, 32};
        tbl[10] = '{F_DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
        tbl[11] = '{F_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 0};
        tbl[12] = '{F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0};
        tbl[13] = '{F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0};
        tbl[14] = '{F_REM,    32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1'b0, 0};
        tbl[15] = '{F_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 32};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_zero", zero, 1'b1);
        @(negedge clk) rst = 1'b0;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, r, z, lat, dc1);
            check($sformatf("vec%0d_result", i), r, tbl[i].exp);
            check($sformatf("vec%0d_zero", i), z, tbl[i].exp_zero);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // DIVU then REMU issued from the DONE cycle: the issue edge ends the first done cycle,
        // so the second done lands 1 + 32 edges later with no idle cycle between.
        run_op("b2b_divu", F_DIVU, 32'hFFFFFFEC, 32'h00000003, r, z, lat, dc1);
        check("b2b_divu_result", r, 32'h5555554E);
        run_op("b2b_remu", F_REMU, 32'hFFFFFFEC, 32'h00000003, r, z, lat, dc2);
        check("b2b_remu_result", r, 32'h00000002);
        check("b2b_gap", dc2 - dc1, 33);

        // kill_i with start_i in a DONE cycle: done still shows, request dropped, unit idles
        prior = result;
        @(negedge clk);
        check("kill_done_cycle_done", done, 1'b1);
        kill = 1'b1; start = 1'b1; funct3 = F_MUL; op1 = 32'h1; op2 = 32'h1;
        @(posedge clk);
        #1 kill = 1'b0; start = 1'b0;
        check("kill_done_next_done", done, 1'b0);
        check("kill_done_next_ready", ready, 1'b1);
        watch_no_done("kill_done_no_done", 40);
        check("kill_done_result_kept", result, prior);

        // kill_i on the 10th CALC edge
        prior = result;
        @(negedge clk);
        start = 1'b1; funct3 = F_MUL; op1 = 32'h12345678; op2 = 32'h00000009;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_calc_ready", ready, 1'b1);
        check("kill_calc_done", done, 1'b0);
        check("kill_calc_result", result, prior);
        watch_no_done("kill_calc_no_done", 40);
        run_op("after_kill", F_MUL, 32'h3, 32'h4, r, z, lat, dc1);
        check("after_kill_result", r, 32'h0000000C);
        check("after_kill_latency", lat, 32);

        // start_i while iterating is ignored
        @(negedge clk);
        start = 1'b1; funct3 = F_MULHU; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) begin start = 1'b1; funct3 = F_MUL; op1 = 32'h2; op2 = 32'h2; end
        @(posedge clk);
        #1 start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("calc_start_drop_result", result, 32'hFFFFFFFE);
        check("calc_start_drop_latency", lat, 32);

        // Narrow instance
        @(negedge clk);
        s8_start = 1'b1; s8_funct3 = F_MULHU; s8_op1 = 8'hFF; s8_op2 = 8'hFF;
        @(posedge clk);
        #1 s8_start = 1'b0;
        lat = 0;
        while (!s8_done && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        check("w8_mulhu_result", s8_result, 8'hFE);
        check("w8_mulhu_latency", lat, 8);

        // Reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct3 = F_MUL; op1 = 32'h5; op2 = 32'h5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_zero", zero, 1'b1);
        @(negedge clk) rst = 1'b0;
        watch_no_done("rst_mid_no_done", 40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
